// File: rtl/vim828_decoder.sv
// vim828_decoder: receive-side decoder for the VIM828 1/3-bias, 4-COM segment LCD.
// It registers the pin level codes and waits for them to settle. Each settled phase
// is then evaluated once, and the selected COM row is captured. When all four rows
// have been seen, a full frame is published.
module vim828_decoder #(
  parameter int SEG_PINS      = 32,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [7:0]              ComLevel_i,
  input  logic [2*SEG_PINS-1:0]   SegLevel_i,
  output logic [4*SEG_PINS-1:0]   Frame_o,
  output logic                    FrameValid_o,
  output logic [1:0]              ActiveCom_o,
  output logic                    Error_o
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]                    com_cur;
  logic [7:0]                    com_prev;
  logic [2*SEG_PINS-1:0]         seg_cur;
  logic [2*SEG_PINS-1:0]         seg_prev;
  logic [CNT_W-1:0]              stable_cnt;
  logic                          armed;
  logic [3:0][SEG_PINS-1:0]      rows;
  logic [3:0]                    seen;

  logic                          changed;
  logic                          fire;
  logic [2:0]                    sel_cnt;
  logic [1:0]                    sel_idx;
  logic [1:0]                    pol;
  logic [1:0]                    idle_lvl;
  logic                          others_ok;
  logic [1:0]                    on_lvl;
  logic [1:0]                    off_lvl;
  logic                          seg_ok;
  logic [SEG_PINS-1:0]           row_bits;
  logic                          eval_ok;
  logic [3:0]                    seen_upd;
  logic [3:0][SEG_PINS-1:0]      rows_upd;

  assign changed  = (com_cur != com_prev) || (seg_cur != seg_prev);
  assign fire     = armed && !changed && (stable_cnt == CNT_MAX);
  assign eval_ok  = (sel_cnt == 3'd1) && others_ok && seg_ok;
  assign seen_upd = seen | (4'b0001 << sel_idx);

  // Register the pins once and keep the previous sample for change detection
  always_ff @(posedge Clock) begin
    com_cur <= ComLevel_i;
    seg_cur <= SegLevel_i;
    if (!Reset) begin
      com_prev <= ComLevel_i;
      seg_prev <= SegLevel_i;
    end else begin
      com_prev <= com_cur;
      seg_prev <= seg_cur;
    end
  end

  // Settling counter: any change restarts the count and re-arms a single evaluation
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else if (changed) begin
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else begin
      if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
      if (fire) begin
        armed <= 1'b0;
      end
    end
  end

  // Find the selected COM (driven to a rail) and check the idle COMs sit at the opposite mid level
  always_comb begin
    sel_cnt   = '0;
    sel_idx   = '0;
    pol       = '0;
    others_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (com_cur[2*i +: 2] == 2'd0 || com_cur[2*i +: 2] == 2'd3) begin
        sel_cnt = sel_cnt + 3'd1;
        sel_idx = 2'(i);
        pol     = com_cur[2*i +: 2];
      end
    end
    idle_lvl = (pol == 2'd0) ? 2'd2 : 2'd1;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != sel_idx && com_cur[2*i +: 2] != idle_lvl) begin
        others_ok = 1'b0;
      end
    end
  end

  // Decode each SEG against the selected polarity: opposite rail is on, near mid level is off
  always_comb begin
    on_lvl   = 2'd3 - pol;
    off_lvl  = (pol == 2'd0) ? 2'd1 : 2'd2;
    seg_ok   = 1'b1;
    row_bits = '0;
    for (int k = 0; k < SEG_PINS; k++) begin
      if (seg_cur[2*k +: 2] == on_lvl) begin
        row_bits[k] = 1'b1;
      end else if (seg_cur[2*k +: 2] != off_lvl) begin
        seg_ok = 1'b0;
      end
    end
  end

  // Row set as it would look with the current capture merged in
  always_comb begin
    rows_upd          = rows;
    rows_upd[sel_idx] = row_bits;
  end

  // Capture rows, assemble frames and flag protocol errors once per settled phase
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rows         <= '0;
      seen         <= '0;
      Frame_o      <= '0;
      FrameValid_o <= 1'b0;
      ActiveCom_o  <= '0;
      Error_o      <= 1'b0;
    end else begin
      FrameValid_o <= 1'b0;
      Error_o      <= 1'b0;
      if (fire) begin
        if (eval_ok) begin
          rows        <= rows_upd;
          ActiveCom_o <= sel_idx;
          if (seen_upd == 4'b1111) begin
            Frame_o      <= rows_upd;
            FrameValid_o <= 1'b1;
            seen         <= '0;
          end else begin
            seen <= seen_upd;
          end
        end else begin
          Error_o <= 1'b1;
          seen    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vim828_decoder.sv
// tb_vim828_decoder: scoreboard bench for vim828_decoder. A run-length view of the
// driven pins predicts each evaluation, and a monitor checks every output event.
module tb_vim828_decoder;
  localparam int SP = 32;
  localparam int SC = 4;

  typedef struct packed {
    logic            is_err;
    logic [4*SP-1:0] frame;
    logic [1:0]      active;
  } exp_t;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic [7:0]      ComLevel_i = '0;
  logic [2*SP-1:0] SegLevel_i = '0;
  logic [4*SP-1:0] Frame_o;
  logic            FrameValid_o;
  logic [1:0]      ActiveCom_o;
  logic            Error_o;

  vim828_decoder #(.SEG_PINS(SP), .STABLE_CYCLES(SC)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .ComLevel_i   (ComLevel_i),
    .SegLevel_i   (SegLevel_i),
    .Frame_o      (Frame_o),
    .FrameValid_o (FrameValid_o),
    .ActiveCom_o  (ActiveCom_o),
    .Error_o      (Error_o)
  );

  always #5 Clock = ~Clock;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int fv_count  = 0;
  int err_count = 0;
  int fv_cyc    = -1;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [7:0]      last_com = '0;
  logic [2*SP-1:0] last_seg = '0;
  int              runlen   = 0;
  bit              pend     = 0;
  logic [7:0]      pend_com = '0;
  logic [2*SP-1:0] pend_seg = '0;
  logic [SP-1:0]   m_rows [4];
  logic [3:0]      m_seen   = '0;
  logic [4*SP-1:0] m_frame  = '0;
  logic [1:0]      m_active = '0;

  // Free-running cycle index used for latency measurement
  always @(posedge Clock) cyc++;

  task automatic checkOutput(input string name, input logic [4*SP-1:0] act, input logic [4*SP-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Evaluate one settled phase from the pin-level rules and queue the expected event
  function automatic void modelApply(input logic [7:0] c, input logic [2*SP-1:0] s);
    int sel[$];
    int p;
    int lvl;
    bit ok;
    logic [SP-1:0] bits;
    bits = '0;
    p    = 0;
    for (int i = 0; i < 4; i++) begin
      lvl = int'(c[2*i +: 2]);
      if (lvl == 0 || lvl == 3) sel.push_back(i);
    end
    ok = (sel.size() == 1);
    if (ok) begin
      p = int'(c[2*sel[0] +: 2]);
      for (int i = 0; i < 4; i++) begin
        if (i != sel[0] && int'(c[2*i +: 2]) != ((p == 0) ? 2 : 1)) ok = 0;
      end
      for (int k = 0; k < SP; k++) begin
        lvl = int'(s[2*k +: 2]);
        if (lvl == 3 - p) bits[k] = 1'b1;
        else if (lvl != ((p == 0) ? 1 : 2)) ok = 0;
      end
    end
    if (ok) begin
      m_rows[sel[0]] = bits;
      m_seen[sel[0]] = 1'b1;
      m_active       = 2'(sel[0]);
      if (m_seen == 4'b1111) begin
        m_frame = {m_rows[3], m_rows[2], m_rows[1], m_rows[0]};
        m_seen  = '0;
        exp_q.push_back('{is_err: 1'b0, frame: m_frame, active: m_active});
      end
    end else begin
      m_seen = '0;
      exp_q.push_back('{is_err: 1'b1, frame: m_frame, active: m_active});
    end
  endfunction

  function automatic logic [7:0] comLv(input int sel, input int p);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = (i == sel) ? 2'(p) : ((p == 0) ? 2'd2 : 2'd1);
    return r;
  endfunction

  function automatic logic [2*SP-1:0] segLv(input int p, input logic [SP-1:0] on);
    logic [2*SP-1:0] r;
    for (int k = 0; k < SP; k++) r[2*k +: 2] = on[k] ? 2'(3 - p) : ((p == 0) ? 2'd1 : 2'd2);
    return r;
  endfunction

  // Hold one pin pattern for n cycles; a phase is evaluated once its run reaches SC+1 cycles
  task automatic applyStimulus(input logic [7:0] c, input logic [2*SP-1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      ComLevel_i = c;
      SegLevel_i = s;
      if (pend) begin
        pend = 0;
        modelApply(pend_com, pend_seg);
      end
      if (c == last_com && s == last_seg) runlen++;
      else runlen = 1;
      last_com = c;
      last_seg = s;
      if (runlen == SC + 1) begin
        pend     = 1;
        pend_com = c;
        pend_seg = s;
      end
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic resetDut(input int n);
    for (int i = 0; i < n; i++) begin
      Reset    = 1'b0;
      pend     = 0;
      runlen   = 2;
      last_com = ComLevel_i;
      last_seg = SegLevel_i;
      for (int r = 0; r < 4; r++) m_rows[r] = '0;
      m_seen   = '0;
      m_frame  = '0;
      m_active = '0;
      @(posedge Clock);
      #1;
    end
    Reset = 1'b1;
  endtask

  // Monitor: every frame or error pulse must match the next expected event
  always @(negedge Clock) begin
    if (FrameValid_o || Error_o) begin
      if (FrameValid_o) begin
        fv_count++;
        fv_cyc = cyc;
      end
      if (Error_o) err_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event actual fv=%0b err=%0b required no event", FrameValid_o, Error_o);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("event_kind", {FrameValid_o, Error_o}, mon_e.is_err ? 2'b01 : 2'b10);
        checkOutput("event_frame", Frame_o, mon_e.frame);
        checkOutput("event_active", ActiveCom_o, mon_e.active);
      end
    end
  end

  // Directed scenarios followed by randomized phases
  initial begin
    int fv0, er0, t, p, c, r, k, hold;
    logic [SP-1:0]   on;
    logic [7:0]      cv;
    logic [2*SP-1:0] sv;

    ComLevel_i = comLv(0, 0);
    SegLevel_i = segLv(0, '0);
    resetDut(2);
    checkOutput("reset_frame", Frame_o, '0);
    checkOutput("reset_fv", FrameValid_o, 0);
    checkOutput("reset_err", Error_o, 0);
    checkOutput("reset_active", ActiveCom_o, 0);

    fv0 = fv_count; er0 = err_count;
    for (int ci = 0; ci < 4; ci++)
      applyStimulus(comLv(ci, 0), segLv(0, (ci == 1) ? 32'h200 : 32'h0), 50);
    checkOutput("static_frames", fv_count - fv0, 1);
    checkOutput("static_errors", err_count - er0, 0);
    checkOutput("static_frame", Frame_o, 128'(1) << 41);
    checkOutput("static_active", ActiveCom_o, 3);

    fv0 = fv_count;
    for (int ci = 0; ci < 4; ci++)
      applyStimulus(comLv(ci, 3), segLv(3, (ci == 1) ? 32'h200 : 32'h0), 30);
    checkOutput("inverted_frames", fv_count - fv0, 1);
    checkOutput("inverted_frame", Frame_o, 128'(1) << 41);

    fv0 = fv_count;
    for (int pi = 0; pi < 2; pi++)
      for (int ci = 0; ci < 4; ci++)
        applyStimulus(comLv(ci, pi * 3), segLv(pi * 3, (ci == 1) ? 32'h200 : 32'h0), 20);
    checkOutput("eight_state_frames", fv_count - fv0, 2);

    fv0 = fv_count; er0 = err_count;
    applyStimulus(comLv(0, 0), segLv(0, 32'h0), 20);
    applyStimulus(comLv(1, 0), segLv(0, 32'h200), 20);
    applyStimulus(comLv(2, 0), segLv(0, 32'h0), 20);
    applyStimulus(comLv(2, 0), segLv(0, 32'h1), 3);
    applyStimulus(comLv(2, 0), segLv(0, 32'h0), 20);
    checkOutput("glitch_no_frame", fv_count - fv0, 0);
    checkOutput("glitch_no_error", err_count - er0, 0);
    applyStimulus(comLv(2, 0), segLv(0, 32'h1), 8);
    applyStimulus(comLv(3, 0), segLv(0, 32'h0), 20);
    checkOutput("glitch_recapture_frames", fv_count - fv0, 1);
    checkOutput("glitch_recapture_frame", Frame_o, (128'(1) << 41) | (128'(1) << 64));

    fv0 = fv_count; er0 = err_count;
    for (int ci = 1; ci < 4; ci++) applyStimulus(comLv(ci, 0), segLv(0, 32'h0), 20);
    applyStimulus({2'd2, 2'd3, 2'd2, 2'd0}, segLv(0, 32'h0), 20);
    checkOutput("two_com_error", err_count - er0, 1);
    applyStimulus(comLv(0, 0), segLv(0, 32'h0), 20);
    checkOutput("seen_cleared", fv_count - fv0, 0);
    for (int ci = 1; ci < 4; ci++) applyStimulus(comLv(ci, 0), segLv(0, 32'hF0F0), 20);
    checkOutput("sweep_after_error", fv_count - fv0, 1);
    sv = segLv(0, 32'h0);
    sv[11:10] = 2'd2;
    applyStimulus(comLv(0, 0), sv, 20);
    checkOutput("bad_seg_error", err_count - er0, 2);

    fv0 = fv_count;
    for (int ci = 0; ci < 3; ci++) applyStimulus(comLv(ci, 3), segLv(3, 32'h3), 20);
    t = cyc;
    applyStimulus(comLv(3, 3), segLv(3, 32'h3), 20);
    checkOutput("latency", fv_cyc - t, 6);
    checkOutput("latency_frames", fv_count - fv0, 1);

    fv0 = fv_count;
    applyStimulus(comLv(0, 0), segLv(0, 32'h55), 20);
    applyStimulus(comLv(1, 0), segLv(0, 32'hAA), 20);
    resetDut(1);
    applyStimulus(comLv(2, 0), segLv(0, 32'h1), 20);
    applyStimulus(comLv(3, 0), segLv(0, 32'h2), 20);
    checkOutput("reset_midframe_frames", fv_count - fv0, 0);
    checkOutput("reset_midframe_frame", Frame_o, '0);

    for (int n = 0; n < 200; n++) begin
      p  = ($urandom_range(0, 1) == 1) ? 3 : 0;
      c  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : n % 4;
      on = $urandom();
      cv = comLv(c, p);
      sv = segLv(p, on);
      r  = $urandom_range(0, 9);
      if (r == 0) cv = 8'($urandom());
      else if (r == 1) begin
        k = $urandom_range(0, SP - 1);
        sv[2*k +: 2] = 2'(p);
      end
      hold = $urandom_range(1, 12);
      applyStimulus(cv, sv, hold);
    end

    applyStimulus(last_com, last_seg, 12);
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge Clock);
    checkOutput("drain_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
